// File: rtl/ltl_monitor_prog.sv
// ---------------------------------------------------------------------------
// ltl_monitor_prog
//
// Programmable automaton monitor built from N_STATES state-transition
// elements (STEs). Each STE matches the incoming symbol against two inclusive
// intervals, is enabled by any active predecessor selected through its edge
// mask or by its start condition, and may flag a report. Reports are counted,
// the first reporting symbol index is captured, and a sticky violation flag
// is raised.
//
// Ports
//   clk, reset_n           : clock (rising edge) and async active-low reset
//   run                    : 1 = consume symbols, 0 = pause (config allowed)
//   clear                  : sync pulse, clears run-time state, keeps config
//   sym_valid/sym_ready/
//   sym_data               : symbol stream handshake
//   cfg_we/cfg_state/
//   cfg_sel/cfg_wdata      : config write port
//                            sel 0/1 : interval {hi, lo}, lo in low SYM_W bits
//                            sel 2   : edge mask, bit j = edge from state j
//                            sel 3   : bit0 report, bits2:1 start type
//   cfg_err                : one-cycle pulse after a rejected config write
//   report_vec/report_any  : states reporting on the last accepted symbol
//   viol_sticky            : set on the first report, held until clear/reset
//   report_cnt             : saturating count of reporting symbols
//   sym_cnt                : wrapping count of accepted symbols
//   first_valid/first_idx  : index of the first reporting symbol
// ---------------------------------------------------------------------------
module ltl_monitor_prog #(
    parameter int SYM_W    = 8,
    parameter int N_STATES = 16,
    parameter int CNT_W    = 16,
    localparam int CFG_W   = (N_STATES > 2*SYM_W) ? N_STATES : 2*SYM_W,
    localparam int SW      = $clog2(N_STATES)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                clear,
    input  logic                sym_valid,
    output logic                sym_ready,
    input  logic [SYM_W-1:0]    sym_data,
    input  logic                cfg_we,
    input  logic [SW-1:0]       cfg_state,
    input  logic [1:0]          cfg_sel,
    input  logic [CFG_W-1:0]    cfg_wdata,
    output logic                cfg_err,
    output logic [N_STATES-1:0] report_vec,
    output logic                report_any,
    output logic                viol_sticky,
    output logic [CNT_W-1:0]    report_cnt,
    output logic [CNT_W-1:0]    sym_cnt,
    output logic                first_valid,
    output logic [CNT_W-1:0]    first_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] START_NONE = 2'd0;
    localparam logic [1:0] START_SOD  = 2'd1;
    localparam logic [1:0] START_ALL  = 2'd2;

    // Inclusive interval test; lo > hi can never be satisfied, so an
    // inverted interval is naturally empty.
    function automatic logic in_range(input logic [SYM_W-1:0] s,
                                      input logic [SYM_W-1:0] lo,
                                      input logic [SYM_W-1:0] hi);
        return (s >= lo) && (s <= hi);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Configuration storage
    logic [SYM_W-1:0]    lo0_q   [N_STATES];
    logic [SYM_W-1:0]    hi0_q   [N_STATES];
    logic [SYM_W-1:0]    lo1_q   [N_STATES];
    logic [SYM_W-1:0]    hi1_q   [N_STATES];
    logic [N_STATES-1:0] edge_q  [N_STATES];
    logic [1:0]          start_q [N_STATES];
    logic [N_STATES-1:0] rep_mask_q;

    // Run-time state
    state_t              state_q;
    logic [N_STATES-1:0] active_q;
    logic [N_STATES-1:0] report_vec_q;
    logic                report_any_q;
    logic                viol_q;
    logic [CNT_W-1:0]    report_cnt_q;
    logic [CNT_W-1:0]    sym_cnt_q;
    logic                first_valid_q;
    logic [CNT_W-1:0]    first_idx_q;
    logic                cfg_err_q;

    logic                accept;
    logic                sod;
    logic                cfg_wr;
    logic [N_STATES-1:0] match;
    logic [N_STATES-1:0] start_en;
    logic [N_STATES-1:0] active_d;
    logic [N_STATES-1:0] report_d;
    logic                rep_hit;

    // clear gates ready, so a symbol offered with clear is never consumed.
    assign sym_ready = run & ~clear;
    assign accept    = sym_valid & sym_ready;
    assign sod       = accept && (state_q == ST_IDLE);
    assign cfg_wr    = cfg_we & ~run;

    always_comb begin
        match    = '0;
        start_en = '0;
        active_d = '0;
        for (int i = 0; i < N_STATES; i++) begin
            match[i]    = in_range(sym_data, lo0_q[i], hi0_q[i]) |
                          in_range(sym_data, lo1_q[i], hi1_q[i]);
            start_en[i] = ((start_q[i] == START_SOD) && sod) ||
                          (start_q[i] == START_ALL);
            active_d[i] = match[i] & ((|(active_q & edge_q[i])) | start_en[i]);
        end
        report_d = active_d & rep_mask_q;
        rep_hit  = |report_d;
    end

    // Configuration write port; writes while running are rejected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_STATES; i++) begin
                lo0_q[i]   <= '1;
                hi0_q[i]   <= '0;
                lo1_q[i]   <= '1;
                hi1_q[i]   <= '0;
                edge_q[i]  <= '0;
                start_q[i] <= START_NONE;
            end
            rep_mask_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we & run;
            for (int i = 0; i < N_STATES; i++) begin
                if (cfg_wr && (cfg_state == SW'(i))) begin
                    case (cfg_sel)
                        2'd0: begin
                            lo0_q[i] <= cfg_wdata[SYM_W-1:0];
                            hi0_q[i] <= cfg_wdata[2*SYM_W-1:SYM_W];
                        end
                        2'd1: begin
                            lo1_q[i] <= cfg_wdata[SYM_W-1:0];
                            hi1_q[i] <= cfg_wdata[2*SYM_W-1:SYM_W];
                        end
                        2'd2: edge_q[i] <= cfg_wdata[N_STATES-1:0];
                        default: begin
                            rep_mask_q[i] <= cfg_wdata[0];
                            start_q[i]    <= cfg_wdata[2:1];
                        end
                    endcase
                end
            end
        end
    end

    // Control FSM: only IDLE matters functionally (it qualifies the
    // start-of-data symbol); RUN/PAUSE track the run input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (accept) state_q <= ST_RUN;
                ST_RUN:   if (!run)   state_q <= ST_PAUSE;
                ST_PAUSE: if (run)    state_q <= ST_RUN;
                default:              state_q <= ST_IDLE;
            endcase
        end
    end

    // Active vector, report outputs, counters and first-report capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q      <= '0;
            report_vec_q  <= '0;
            report_any_q  <= 1'b0;
            viol_q        <= 1'b0;
            report_cnt_q  <= '0;
            sym_cnt_q     <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
        end else if (clear) begin
            active_q      <= '0;
            report_vec_q  <= '0;
            report_any_q  <= 1'b0;
            viol_q        <= 1'b0;
            report_cnt_q  <= '0;
            sym_cnt_q     <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
        end else if (accept) begin
            active_q     <= active_d;
            report_vec_q <= report_d;
            report_any_q <= rep_hit;
            sym_cnt_q    <= sym_cnt_q + CNT_W'(1);
            if (rep_hit) begin
                report_cnt_q <= sat_inc(report_cnt_q);
                viol_q       <= 1'b1;
                if (!first_valid_q) begin
                    first_valid_q <= 1'b1;
                    first_idx_q   <= sym_cnt_q;
                end
            end
        end else begin
            // Report outputs describe only the symbol just accepted.
            report_vec_q <= '0;
            report_any_q <= 1'b0;
        end
    end

    assign cfg_err     = cfg_err_q;
    assign report_vec  = report_vec_q;
    assign report_any  = report_any_q;
    assign viol_sticky = viol_q;
    assign report_cnt  = report_cnt_q;
    assign sym_cnt     = sym_cnt_q;
    assign first_valid = first_valid_q;
    assign first_idx   = first_idx_q;

endmodule

// File: tb/tb_ltl_monitor_prog.sv
module tb_ltl_monitor_prog;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        clear;
    logic        sym_valid;
    logic [7:0]  sym_data;
    logic        cfg_we;
    logic [3:0]  cfg_state;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_wdata;

    logic        sym_ready, cfg_err, report_any, viol_sticky, first_valid;
    logic [15:0] report_vec, report_cnt, sym_cnt, first_idx;

    logic        sym_ready4, cfg_err4, report_any4, viol_sticky4, first_valid4;
    logic [15:0] report_vec4;
    logic [3:0]  report_cnt4, sym_cnt4, first_idx4;

    int nchecks = 0;
    int nerrors = 0;

    ltl_monitor_prog dut (
        .clk(clk), .reset_n(reset_n), .run(run), .clear(clear),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
        .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_sel(cfg_sel),
        .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .report_vec(report_vec),
        .report_any(report_any), .viol_sticky(viol_sticky),
        .report_cnt(report_cnt), .sym_cnt(sym_cnt),
        .first_valid(first_valid), .first_idx(first_idx)
    );

    ltl_monitor_prog #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .run(run), .clear(clear),
        .sym_valid(sym_valid), .sym_ready(sym_ready4), .sym_data(sym_data),
        .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_sel(cfg_sel),
        .cfg_wdata(cfg_wdata), .cfg_err(cfg_err4), .report_vec(report_vec4),
        .report_any(report_any4), .viol_sticky(viol_sticky4),
        .report_cnt(report_cnt4), .sym_cnt(sym_cnt4),
        .first_valid(first_valid4), .first_idx(first_idx4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        valid;
        logic [7:0]  sym;
        logic        exp_any;
        logic [15:0] exp_vec;
        logic [15:0] exp_scnt;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int st, input int sel, input logic [15:0] d);
        run       = 1'b0;
        sym_valid = 1'b0;
        cfg_we    = 1'b1;
        cfg_state = 4'(st);
        cfg_sel   = 2'(sel);
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        chk("cfg_err_on_legal_write", cfg_err, 0);
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            run       = tbl[k].run;
            sym_valid = tbl[k].valid;
            sym_data  = tbl[k].sym;
            tick();
            chk($sformatf("row%0d_report_any", k), report_any, tbl[k].exp_any);
            chk($sformatf("row%0d_report_vec", k), report_vec, tbl[k].exp_vec);
            chk($sformatf("row%0d_sym_cnt", k), sym_cnt, tbl[k].exp_scnt);
        end
    endtask

    task automatic send(input logic [7:0] s);
        run       = 1'b1;
        sym_valid = 1'b1;
        sym_data  = s;
        tick();
    endtask

    initial begin
        // Start-of-data: S0 [0,31]|[128,159], self edge, report
        tbl[0] = '{1'b1, 1'b1, 8'd5,   1'b1, 16'h0001, 16'd1};
        tbl[1] = '{1'b1, 1'b1, 8'd140, 1'b1, 16'h0001, 16'd2};
        tbl[2] = '{1'b1, 1'b1, 8'd40,  1'b0, 16'h0000, 16'd3};
        tbl[3] = '{1'b0, 1'b1, 8'd5,   1'b0, 16'h0000, 16'd3};
        tbl[4] = '{1'b1, 1'b1, 8'd5,   1'b0, 16'h0000, 16'd4};
        tbl[5] = '{1'b1, 1'b0, 8'd5,   1'b0, 16'h0000, 16'd4};
        // Chain: S0 all-input [0,31] -> S1 [32,63] report
        tbl[6] = '{1'b1, 1'b1, 8'd10,  1'b0, 16'h0000, 16'd1};
        tbl[7] = '{1'b1, 1'b1, 8'd50,  1'b1, 16'h0002, 16'd2};
        tbl[8] = '{1'b1, 1'b1, 8'd10,  1'b0, 16'h0000, 16'd3};
        tbl[9] = '{1'b1, 1'b1, 8'd40,  1'b1, 16'h0002, 16'd4};

        reset_n = 1'b0; run = 1'b0; clear = 1'b0; sym_valid = 1'b0;
        sym_data = '0; cfg_we = 1'b0; cfg_state = '0; cfg_sel = '0; cfg_wdata = '0;
        #12;
        chk("rst_sym_ready", sym_ready, 0);
        chk("rst_report_any", report_any, 0);
        chk("rst_report_vec", report_vec, 0);
        chk("rst_sym_cnt", sym_cnt, 0);
        chk("rst_report_cnt", report_cnt, 0);
        chk("rst_viol", viol_sticky, 0);
        chk("rst_first_valid", first_valid, 0);
        chk("rst_first_idx", first_idx, 0);
        chk("rst_cfg_err", cfg_err, 0);
        tick();
        reset_n = 1'b1;
        tick();

        cfg_write(0, 0, 16'h1F00);
        cfg_write(0, 1, 16'h9F80);
        cfg_write(0, 2, 16'h0001);
        cfg_write(0, 3, 16'h0003);
        apply_rows(0, 5);
        chk("sod_first_idx", first_idx, 0);
        chk("sod_first_valid", first_valid, 1);
        chk("sod_viol", viol_sticky, 1);
        chk("sod_report_cnt", report_cnt, 2);

        // Clear with a symbol offered at the same time
        run = 1'b1; sym_valid = 1'b1; sym_data = 8'd5;
        #1;
        chk("ready_running", sym_ready, 1);
        clear = 1'b1;
        #1;
        chk("ready_during_clear", sym_ready, 0);
        tick();
        clear = 1'b0;
        chk("clr_sym_cnt", sym_cnt, 0);
        chk("clr_report_cnt", report_cnt, 0);
        chk("clr_viol", viol_sticky, 0);
        chk("clr_first_valid", first_valid, 0);
        send(8'd5);
        chk("post_clr_sod_any", report_any, 1);
        chk("post_clr_sod_vec", report_vec, 16'h0001);
        chk("post_clr_sym_cnt", sym_cnt, 1);
        chk("post_clr_first_idx", first_idx, 0);

        cfg_write(0, 0, 16'h1F00);
        cfg_write(0, 1, 16'h00FF);
        cfg_write(0, 2, 16'h0000);
        cfg_write(0, 3, 16'h0004);
        cfg_write(1, 0, 16'h3F20);
        cfg_write(1, 1, 16'h00FF);
        cfg_write(1, 2, 16'h0001);
        cfg_write(1, 3, 16'h0001);
        clear_pulse();
        apply_rows(6, 9);
        chk("chain_first_idx", first_idx, 1);
        chk("chain_report_cnt", report_cnt, 2);

        // Config write while running is rejected
        run = 1'b1; sym_valid = 1'b0;
        cfg_we = 1'b1; cfg_state = 4'd1; cfg_sel = 2'd3; cfg_wdata = 16'h0000;
        tick();
        cfg_we = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        tick();
        chk("cfg_err_drop", cfg_err, 0);
        send(8'd10);
        send(8'd50);
        chk("rejected_cfg_vec", report_vec, 16'h0002);
        chk("rejected_cfg_report_cnt", report_cnt, 3);

        // Saturation: S0 all-input, [0,255], report
        cfg_write(0, 0, 16'hFF00);
        cfg_write(0, 3, 16'h0005);
        clear_pulse();
        for (int k = 0; k < 20; k++) send(8'd0);
        chk("sat4_report_cnt", report_cnt4, 15);
        chk("sat4_sym_cnt", sym_cnt4, 4);
        chk("sat4_first_idx", first_idx4, 0);
        chk("sat16_report_cnt", report_cnt, 20);
        chk("sat16_sym_cnt", sym_cnt, 20);

        // Reset mid-stream
        clear_pulse();
        for (int k = 0; k < 5; k++) send(8'd0);
        chk("pre_rst_sym_cnt", sym_cnt, 5);
        run = 1'b0; sym_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("mid_rst_report_any", report_any, 0);
        chk("mid_rst_report_vec", report_vec, 0);
        chk("mid_rst_sym_cnt", sym_cnt, 0);
        chk("mid_rst_report_cnt", report_cnt, 0);
        chk("mid_rst_viol", viol_sticky, 0);
        chk("mid_rst_first_valid", first_valid, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        send(8'd0);
        send(8'd40);
        chk("post_rst_any", report_any, 0);
        chk("post_rst_sym_cnt", sym_cnt, 2);
        chk("post_rst_report_cnt", report_cnt, 0);
        chk("post_rst_viol", viol_sticky, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
